// File: rtl/if_fetch_queue.sv
// Fetch PC generator, single-outstanding imem requester and
// instruction queue feeding decode.
module if_fetch_queue #(
  parameter int IQ_DEPTH = 4,
  parameter int PC_W     = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic            proc2Imem_req_o,
  output logic [PC_W-1:0] proc2Imem_addr_o,
  input  logic            Imem_valid_i,
  input  logic [63:0]     Imem2proc_data_i,
  input  logic            redirect_en_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [31:0]     if_id_IR_o,
  output logic [PC_W-1:0] if_id_NPC_o,
  output logic            if_id_valid_inst_o,
  input  logic            id_ready_i
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP,
    S_HALTED
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_req_pc;
  logic [31:0]     r_ir  [IQ_DEPTH];
  logic [PC_W-1:0] r_npc [IQ_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_req;
  logic            w_enq;
  logic            w_deq;
  logic            w_outst;
  logic            w_halt;
  logic [31:0]     w_word;
  logic [PC_W-1:0] w_npc;
  logic            w_unused;

  assign w_unused = ^redirect_pc_i[1:0];

  assign w_full = (r_count == CW'(IQ_DEPTH));
  // rst gates req so it drops the moment reset asserts
  assign w_req  = rst && (r_state == S_FETCH)
               && !w_full && !redirect_en_i;
  assign w_enq  = (r_state == S_WAIT) && Imem_valid_i
               && !redirect_en_i;
  assign w_deq  = (r_count != '0) && id_ready_i
               && !redirect_en_i;
  assign w_outst = ((r_state == S_WAIT) || (r_state == S_DROP))
                && !Imem_valid_i;

  assign w_word = r_req_pc[2] ? Imem2proc_data_i[63:32]
                              : Imem2proc_data_i[31:0];
  assign w_npc  = r_req_pc + PC_W'(4);
  assign w_halt = (w_word == 32'h0000_0555);

  assign proc2Imem_req_o    = w_req;
  assign proc2Imem_addr_o   = {r_pc[PC_W-1:3], 3'b000};
  assign if_id_valid_inst_o = (r_count != '0);
  assign if_id_IR_o         = r_ir[r_head];
  assign if_id_NPC_o        = r_npc[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_req_pc <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else if (redirect_en_i) begin
      r_pc    <= {redirect_pc_i[PC_W-1:2], 2'b00};
      r_state <= w_outst ? S_DROP : S_FETCH;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      if (w_enq && !w_deq)
        r_count <= r_count + 1'b1;
      else if (!w_enq && w_deq)
        r_count <= r_count - 1'b1;
      unique case (r_state)
        S_FETCH: begin
          if (w_req) begin
            r_state  <= S_WAIT;
            r_req_pc <= r_pc;
          end
        end
        S_WAIT: begin
          if (Imem_valid_i) begin
            r_pc    <= w_npc;
            r_state <= w_halt ? S_HALTED : S_FETCH;
          end
        end
        S_DROP: begin
          if (Imem_valid_i) r_state <= S_FETCH;
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        r_ir[i]  <= '0;
        r_npc[i] <= '0;
      end
    end else if (w_enq) begin
      r_ir[r_tail]  <= w_word;
      r_npc[r_tail] <= w_npc;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table, directed corner
// sequences and a randomized run against a queue-based model.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req;
  logic [63:0] addr;
  logic        iv;
  logic [63:0] data;
  logic        redirect;
  logic [63:0] rpc;
  logic [31:0] ir;
  logic [63:0] npc;
  logic        valid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  if_fetch_queue #(.IQ_DEPTH(4), .PC_W(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .proc2Imem_req_o    (req),
    .proc2Imem_addr_o   (addr),
    .Imem_valid_i       (iv),
    .Imem2proc_data_i   (data),
    .redirect_en_i      (redirect),
    .redirect_pc_i      (rpc),
    .if_id_IR_o         (ir),
    .if_id_NPC_o        (npc),
    .if_id_valid_inst_o (valid),
    .id_ready_i         (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic        iv;
    logic [63:0] dat;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_v;
    logic [31:0] e_ir;
    logic [63:0] e_npc;
    logic        chk_d;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] npc;
  } ent_t;

  vec_t tv [16];

  function automatic vec_t mk(
    input logic redir, input logic [63:0] rp,
    input logic rdy, input logic v_i,
    input logic [63:0] dat, input logic e_req,
    input logic [63:0] e_addr, input logic e_v,
    input logic [31:0] e_ir, input logic [63:0] e_npc,
    input logic chk_d);
    vec_t t;
    t.redir = redir; t.rpc = rp; t.rdy = rdy;
    t.iv = v_i; t.dat = dat; t.e_req = e_req;
    t.e_addr = e_addr; t.e_v = e_v; t.e_ir = e_ir;
    t.e_npc = e_npc; t.chk_d = chk_d;
    return t;
  endfunction

  function automatic logic [31:0] word_at(
    input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1 + a[63:32];
    if (h[31:27] == 5'd0) return 32'h0000_0555;
    return h;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, a, e);
    end
  endtask

  task automatic idle();
    redirect = 1'b0;
    rpc      = '0;
    ready    = 1'b0;
    iv       = 1'b0;
    data     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #4;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  logic [63:0] m_pc, m_reqpc, maddr, e_addr;
  logic [31:0] w;
  bit          m_out, m_drop, m_halt, e_req, mpend;
  int          mcnt, enq;
  ent_t        mq [$];

  initial begin
    idle();
    tv[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tv[2]  = mk(0, 0, 0, 1, {32'hB, 32'hA},
                0, 0, 0, 0, 0, 1);
    tv[3]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 32'hA, 4, 1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 4, 1);
    tv[5]  = mk(0, 0, 0, 1, {32'hB, 32'hA},
                0, 0, 1, 32'hA, 4, 1);
    tv[6]  = mk(0, 0, 1, 0, 0, 1, 8, 1, 32'hA, 4, 1);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 8, 1, 32'hB, 8, 1);
    tv[8]  = mk(0, 0, 0, 1, {32'hDEAD_BEEF, 32'h555},
                0, 8, 1, 32'hB, 8, 1);
    tv[9]  = mk(0, 0, 1, 0, 0, 0, 8, 1, 32'hB, 8, 1);
    tv[10] = mk(0, 0, 1, 0, 0, 0, 8, 1, 32'h555, 12, 1);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
    tv[13] = mk(1, 64'h23, 0, 0, 0, 0, 8, 0, 0, 0, 0);
    tv[14] = mk(0, 0, 0, 0, 0, 1, 64'h20, 0, 0, 0, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 64'h20, 0, 0, 0, 0);

    // reset values observed while rst is held low
    #7;
    chk("rst_req", {63'd0, req}, 0);
    chk("rst_valid", {63'd0, valid}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ir", {32'd0, ir}, 0);
    chk("rst_npc", npc, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      redirect = tv[i].redir;
      rpc      = tv[i].rpc;
      ready    = tv[i].rdy;
      iv       = tv[i].iv;
      data     = tv[i].dat;
      samp();
      chk($sformatf("tv%0d_req", i), {63'd0, req},
          {63'd0, tv[i].e_req});
      chk($sformatf("tv%0d_addr", i), addr, tv[i].e_addr);
      chk($sformatf("tv%0d_valid", i), {63'd0, valid},
          {63'd0, tv[i].e_v});
      if (tv[i].chk_d) begin
        chk($sformatf("tv%0d_ir", i), {32'd0, ir},
            {32'd0, tv[i].e_ir});
        chk($sformatf("tv%0d_npc", i), npc, tv[i].e_npc);
      end
      tick();
    end

    // redirect while a request is outstanding
    do_reset();
    samp();
    chk("a_req", {63'd0, req}, 1);
    tick();
    redirect = 1'b1;
    rpc = 64'h1000;
    samp();
    chk("a_redir_req", {63'd0, req}, 0);
    tick();
    idle();
    iv = 1'b1;
    data = {32'h1111_0001, 32'h1111_0000};
    samp();
    chk("a_drop_req", {63'd0, req}, 0);
    chk("a_drop_valid", {63'd0, valid}, 0);
    tick();
    idle();
    samp();
    chk("a_tgt_req", {63'd0, req}, 1);
    chk("a_tgt_addr", addr, 64'h1000);
    chk("a_tgt_valid", {63'd0, valid}, 0);
    tick();
    iv = 1'b1;
    data = {32'h0, 32'hCAFE_0001};
    samp();
    chk("a_wait_valid", {63'd0, valid}, 0);
    tick();
    idle();
    samp();
    chk("a_out_valid", {63'd0, valid}, 1);
    chk("a_out_ir", {32'd0, ir}, 64'hCAFE_0001);
    chk("a_out_npc", npc, 64'h1004);
    tick();

    // backpressure until full, then flush with ready high
    do_reset();
    mpend = 0;
    enq = 0;
    for (int c = 0; c < 40 && enq < 4; c++) begin
      idle();
      iv = mpend;
      data = {32'h2222_2222, 32'h1111_1111};
      if (mpend) enq++;
      samp();
      mpend = req;
      tick();
    end
    chk("full_fill", 64'(enq), 4);
    idle();
    for (int c = 0; c < 3; c++) begin
      samp();
      chk("full_req", {63'd0, req}, 0);
      chk("full_valid", {63'd0, valid}, 1);
      tick();
    end
    ready = 1'b1;
    samp();
    chk("full_deq_req", {63'd0, req}, 0);
    tick();
    idle();
    samp();
    chk("full_rereq", {63'd0, req}, 1);
    tick();
    redirect = 1'b1;
    rpc = 64'h2000;
    ready = 1'b1;
    samp();
    chk("flush_pre_valid", {63'd0, valid}, 1);
    tick();
    idle();
    ready = 1'b1;
    iv = 1'b1;
    data = {32'hBAD0_0001, 32'hBAD0_0000};
    samp();
    chk("flush_valid", {63'd0, valid}, 0);
    chk("flush_drop_req", {63'd0, req}, 0);
    tick();
    idle();
    ready = 1'b1;
    samp();
    chk("flush_tgt_req", {63'd0, req}, 1);
    chk("flush_tgt_addr", addr, 64'h2000);
    chk("flush_tgt_valid", {63'd0, valid}, 0);
    tick();
    ready = 1'b1;
    iv = 1'b1;
    data = {32'h0, 32'h4444_0000};
    samp();
    chk("flush_wait_valid", {63'd0, valid}, 0);
    tick();
    idle();
    samp();
    chk("flush_new_valid", {63'd0, valid}, 1);
    chk("flush_new_ir", {32'd0, ir}, 64'h4444_0000);
    chk("flush_new_npc", npc, 64'h2004);
    tick();

    // asynchronous reset while waiting on memory
    do_reset();
    redirect = 1'b1;
    rpc = 64'h3000;
    samp();
    tick();
    idle();
    samp();
    chk("d_req", {63'd0, req}, 1);
    chk("d_addr", addr, 64'h3000);
    tick();
    iv = 1'b1;
    data = {32'h0, 32'h9999};
    samp();
    tick();
    idle();
    samp();
    chk("d_valid", {63'd0, valid}, 1);
    chk("d_req2_addr", addr, 64'h3000);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("d_rst_req", {63'd0, req}, 0);
    chk("d_rst_valid", {63'd0, valid}, 0);
    chk("d_rst_addr", addr, 0);
    chk("d_rst_ir", {32'd0, ir}, 0);
    chk("d_rst_npc", npc, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    iv = 1'b1;
    data = {32'hEEEE_0001, 32'hEEEE_0000};
    samp();
    chk("d_restart_req", {63'd0, req}, 1);
    chk("d_restart_addr", addr, 0);
    tick();
    idle();
    iv = 1'b1;
    data = {32'h0, 32'h777};
    samp();
    chk("d_wait_req", {63'd0, req}, 0);
    chk("d_wait_valid", {63'd0, valid}, 0);
    tick();
    idle();
    samp();
    chk("d_out_valid", {63'd0, valid}, 1);
    chk("d_out_ir", {32'd0, ir}, 64'h777);
    chk("d_out_npc", npc, 4);
    tick();

    // randomized run against the queue model
    do_reset();
    mq.delete();
    m_pc = 0; m_reqpc = 0; maddr = 0;
    m_out = 0; m_drop = 0; m_halt = 0;
    mpend = 0; mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect = ($urandom % 20 == 0);
      if ($urandom % 4 == 0)
        rpc = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom)};
      else
        rpc = {52'd0, 12'($urandom)};
      ready = ($urandom % 3 != 0);
      iv = mpend && (mcnt == 0);
      if (!mpend && ($urandom % 10 == 0)) iv = 1'b1;
      if (iv && mpend)
        data = {word_at(maddr + 4), word_at(maddr)};
      else
        data = {$urandom, $urandom};
      samp();
      e_req = !m_halt && !m_out && (mq.size() < 4)
           && !redirect;
      e_addr = {m_pc[63:3], 3'b000};
      chk("rnd_req", {63'd0, req}, {63'd0, e_req});
      chk("rnd_addr", addr, e_addr);
      chk("rnd_valid", {63'd0, valid},
          {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("rnd_ir", {32'd0, ir}, {32'd0, mq[0].ir});
        chk("rnd_npc", npc, mq[0].npc);
      end
      if (iv) mpend = 0;
      else if (mpend) mcnt--;
      if (redirect) begin
        mq.delete();
        m_halt = 0;
        m_pc = rpc & ~64'h3;
        m_drop = m_out && !iv;
        m_out = m_out && !iv;
      end else begin
        if (mq.size() != 0 && ready) void'(mq.pop_front());
        if (m_out && iv) begin
          if (!m_drop) begin
            w = m_reqpc[2] ? data[63:32] : data[31:0];
            mq.push_back('{w, m_reqpc + 64'd4});
            m_pc = m_reqpc + 64'd4;
            if (w == 32'h0000_0555) m_halt = 1;
          end
          m_out = 0;
          m_drop = 0;
        end else if (e_req) begin
          m_out = 1;
          m_reqpc = m_pc;
          mpend = 1;
          mcnt = $urandom_range(0, 2);
          maddr = e_addr;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Fetch-side producer for the decode stage: generates the fetch PC, issues single-outstanding requests to instruction memory, and buffers returned 32-bit Alpha instructions with their NPC in a small FIFO. Decode pulls from the FIFO head with a valid/ready handshake. A branch/recovery redirect flushes the queue and restarts fetch. A PAL HALT stops fetching once the HALT has been queued.

## Interface
- IQ_DEPTH, 4, instruction queue entries (power of two, ≥2)
- PC_W, 64, PC/address width
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- proc2Imem_req_o  output  1  fetch request, valid for one cycle; memory always accepts
- proc2Imem_addr_o  output  PC_W  8-byte-aligned line address, {pc[PC_W-1:3],3'b0}
- Imem_valid_i  input  1  response strobe, one cycle, earliest the cycle after the request
- Imem2proc_data_i  input  64  fetched line: [31:0] is the word at pc[2]=0, [63:32] is the word at pc[2]=1
- redirect_en_i  input  1  flush queue and redirect fetch
- redirect_pc_i  input  PC_W  new fetch PC; bits [1:0] ignored
- if_id_IR_o  output  32  head instruction
- if_id_NPC_o  output  PC_W  head PC+4
- if_id_valid_inst_o  output  1  head entry valid
- id_ready_i  input  1  decode consumes the head this cycle when valid

## Operation
- State: pc register, queue (IR, NPC per entry), head/tail pointers, count (0..IQ_DEPTH), and FSM {FETCH, WAIT, DROP, HALTED}.
- FETCH:
  - proc2Imem_req_o = (count < IQ_DEPTH) && !redirect_en_i.
  - A request moves the FSM to WAIT and latches the requested pc as req_pc.
- WAIT, on Imem_valid_i:
  - Select the word Imem2proc_data_i[req_pc[2]*32 +: 32].
  - Enqueue {word, req_pc+4} at the tail, then set pc = req_pc+4.
  - If word[31:26]==6'h00 and word[25:0]==26'h555 (PAL HALT): go to HALTED. Otherwise go to FETCH.
- DROP, on Imem_valid_i: discard the data and go to FETCH. The pc already holds the redirect target.
- HALTED: no requests; the queue continues to drain to decode.
- Redirect (highest priority, any state):
  - count, head and tail are cleared; pc = {redirect_pc_i[PC_W-1:2],2'b00}.
  - Next state is DROP if a request is outstanding (in WAIT without Imem_valid_i that cycle), otherwise FETCH.
  - A response arriving in the same cycle as a redirect is discarded.
  - A dequeue in the redirect cycle is not honored as a consume; the head is flushed.
- Dequeue when if_id_valid_inst_o && id_ready_i. Head advances modulo IQ_DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full: a new request is only issued when count < IQ_DEPTH, and at most one request is outstanding, so a response always has a free slot. No overflow path exists.
- Imem_valid_i in FETCH or HALTED (no outstanding request) is ignored.
- Pointers wrap modulo IQ_DEPTH. pc+4 wraps modulo 2^PC_W.

## Timing
- Reset (asynchronous, rst=0): pc=0, FSM=FETCH, count=0, pointers=0. Outputs: proc2Imem_req_o=0 while in reset, if_id_valid_inst_o=0, if_id_IR_o=0, if_id_NPC_o=0, proc2Imem_addr_o=0.
- First cycle after rst rises: req=1, addr=0.
- Latency: response at cycle N → if_id_valid_inst_o=1 at cycle N+1. The next request can be issued in cycle N+1, the earliest.
- Outputs:
  - if_id_valid_inst_o = (count != 0), registered-state driven.
  - IR and NPC come from the head entry and hold stable while valid && !ready.
  - Contents when count==0 are don't-care, but must be 0 after reset.
- Redirect at cycle R: queue empty (valid=0) at R+1. A request to the target is issued at R+1 if the FSM is FETCH, or one cycle after the stale response is dropped if it is DROP.
- Throughput: one instruction per memory round trip. There is no prefetch of the second word in the line.

## Test plan
- Reset fetch: after rst rises, req at cycle 1 with addr=0. Respond at cycle 3 with data {32'hB,32'hA} → cycle 4: IR=32'hA, NPC=4, valid=1. The next request has addr=0 and selects the upper word (pc=4).
- Backpressure and full: hold id_ready_i=0 with 1-cycle memory. After 4 enqueues, req stays 0 and count=4. Raise ready for one cycle → one dequeue, and req re-asserts the following cycle.
- Redirect with outstanding request: in WAIT, pulse redirect to 0x1000. The stale response is dropped (never appears at decode). The next req has addr=0x1000 and the first decoded NPC=0x1004.
- Redirect while the queue holds 3 entries and ready=1: valid=0 the next cycle, and no flushed entry is consumed after the redirect cycle.
- HALT: the word at pc=8 is 32'h0000_0555 → it is enqueued, no further req while HALTED, the queue drains, and valid drops to 0. A redirect to 0x20 resumes fetch.
- Async reset mid-WAIT: assert rst=0 between clock edges → outputs clear immediately. A late Imem_valid_i after release is ignored, and fetch restarts at addr 0.
